// File: rtl/adc_sample_averager_pkg.sv
// Shared constants for the ADC sample averager: FSM encodings and sample-count clamp helper.
package adc_sample_averager_pkg;

    localparam int unsigned STATE_W      = 3;
    localparam int unsigned AVG_LOG2_W   = 3;
    localparam int unsigned DEF_MAX_LOG2 = 4;

    localparam logic [STATE_W-1:0] ST_IDLE = 3'd0;
    localparam logic [STATE_W-1:0] ST_WAIT = 3'd1;
    localparam logic [STATE_W-1:0] ST_ACC  = 3'd2;
    localparam logic [STATE_W-1:0] ST_DIV  = 3'd3;
    localparam logic [STATE_W-1:0] ST_DONE = 3'd4;

    // Requested log2(sample count) limited to what the accumulator can hold.
    function automatic logic [AVG_LOG2_W-1:0] clamp_log2(
        input logic [AVG_LOG2_W-1:0] req,
        input logic [AVG_LOG2_W-1:0] max_log2
    );
        return (req > max_log2) ? max_log2 : req;
    endfunction

endpackage

// File: rtl/adc_edge_sync.sv
// Registered rising-edge detectors for the measurement request and the ADC ready level.
module adc_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic rdy,
    output logic launch_c,
    output logic sample_c
);

    logic start_q;
    logic rdy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            start_q <= start;
            rdy_q   <= rdy;
        end
    end

    assign launch_c = start & ~start_q;
    assign sample_c = rdy & ~rdy_q;

endmodule

// File: rtl/adc_sample_averager.sv
// Captures ADC conversions on ADC_RDY rising edges and reports the rounded mean of 2^n samples.
module adc_sample_averager
    import adc_sample_averager_pkg::*;
#(
    parameter int unsigned CADC_WIDTH = 10,
    parameter int unsigned MAX_LOG2   = DEF_MAX_LOG2,
    parameter int unsigned TMO_WIDTH  = 16
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  MEAS_START,
    input  logic [AVG_LOG2_W-1:0] AVG_LOG2,
    input  logic [TMO_WIDTH-1:0]  TMO_LIMIT,
    input  logic [CADC_WIDTH-1:0] ADC,
    input  logic                  ADC_RDY,
    output logic [CADC_WIDTH-1:0] AVG_DATA,
    output logic                  MEAS_DONE,
    output logic                  MEAS_BUSY,
    output logic                  TIMEOUT
);

    localparam int unsigned ACC_W = CADC_WIDTH + MAX_LOG2;
    localparam int unsigned SUM_W = ACC_W + 1;
    localparam int unsigned CNT_W = MAX_LOG2 + 1;
    localparam logic [AVG_LOG2_W-1:0] MAX_N   = AVG_LOG2_W'(MAX_LOG2);
    localparam logic [SUM_W-1:0]      SAT_MAX = SUM_W'({CADC_WIDTH{1'b1}});

    logic                  launch_c;
    logic                  sample_c;
    logic [STATE_W-1:0]    state;
    logic [STATE_W-1:0]    state_nxt;
    logic [AVG_LOG2_W-1:0] n_q;
    logic [ACC_W-1:0]      acc;
    logic [CNT_W-1:0]      cnt;
    logic [TMO_WIDTH-1:0]  tmo;

    logic                  clr_c, add_c, tmo_step_c, set_tmo_c, div_c;
    logic                  last_c, tmo_hit_c;
    logic [CNT_W-1:0]      cnt_inc_c;
    logic [TMO_WIDTH-1:0]  tmo_inc_c;
    logic [SUM_W-1:0]      rnd_c, rnd_sum_c, shifted_c;
    logic [CADC_WIDTH-1:0] avg_c;

    adc_edge_sync u_edge_sync (
        .clk      (CLK),
        .rst_n    (RST_N),
        .start    (MEAS_START),
        .rdy      (ADC_RDY),
        .launch_c (launch_c),
        .sample_c (sample_c)
    );

    // Sample-count and per-sample timeout comparisons.
    always_comb begin
        cnt_inc_c = cnt + CNT_W'(1);
        last_c    = (cnt_inc_c == (CNT_W'(1) << n_q));
        tmo_inc_c = tmo + TMO_WIDTH'(1);
        tmo_hit_c = (TMO_LIMIT != '0) && (tmo_inc_c == TMO_LIMIT);
    end

    // Round-half-up divide by 2^n, one bit wider than the accumulator so the add cannot wrap.
    always_comb begin
        rnd_c = '0;
        if (n_q != '0) begin
            rnd_c = SUM_W'(1) << (n_q - AVG_LOG2_W'(1));
        end
        rnd_sum_c = {1'b0, acc} + rnd_c;
        shifted_c = rnd_sum_c >> n_q;
        avg_c     = (shifted_c > SAT_MAX) ? '1 : shifted_c[CADC_WIDTH-1:0];
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and datapath strobes; a dropped request always wins over sample/timeout.
    always_comb begin
        state_nxt  = state;
        clr_c      = 1'b0;
        add_c      = 1'b0;
        tmo_step_c = 1'b0;
        set_tmo_c  = 1'b0;
        div_c      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (launch_c) begin
                    state_nxt = ST_WAIT;
                    clr_c     = 1'b1;
                end
            end
            ST_WAIT: begin
                if (!MEAS_START) begin
                    state_nxt = ST_IDLE;
                end else if (sample_c) begin
                    add_c = 1'b1;
                    if (last_c) begin
                        state_nxt = ST_DIV;
                    end
                end else if (tmo_hit_c) begin
                    state_nxt = ST_DONE;
                    set_tmo_c = 1'b1;
                end else begin
                    tmo_step_c = 1'b1;
                end
            end
            ST_DIV: begin
                if (!MEAS_START) begin
                    state_nxt = ST_IDLE;
                end else begin
                    div_c     = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!MEAS_START) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            n_q <= '0;
            acc <= '0;
            cnt <= '0;
            tmo <= '0;
        end else if (clr_c) begin
            n_q <= clamp_log2(AVG_LOG2, MAX_N);
            acc <= '0;
            cnt <= '0;
            tmo <= '0;
        end else if (add_c) begin
            acc <= acc + ACC_W'(ADC);
            cnt <= cnt_inc_c;
            tmo <= '0;
        end else if (tmo_step_c) begin
            tmo <= tmo_inc_c;
        end
    end

    // Status and result registers; MEAS_DONE trails the DONE state by one cycle.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            AVG_DATA  <= '0;
            MEAS_DONE <= 1'b0;
            MEAS_BUSY <= 1'b0;
            TIMEOUT   <= 1'b0;
        end else begin
            MEAS_DONE <= (state == ST_DONE);
            MEAS_BUSY <= (state_nxt == ST_WAIT) || (state_nxt == ST_ACC) || (state_nxt == ST_DIV);
            if (clr_c) begin
                TIMEOUT <= 1'b0;
            end else if (set_tmo_c) begin
                TIMEOUT <= 1'b1;
            end
            if (div_c) begin
                AVG_DATA <= avg_c;
            end
        end
    end

endmodule

// File: tb/tb_adc_sample_averager.sv
// Bench for adc_sample_averager: directed corner sequences, a vector table and a randomized model check.
`timescale 1ns/1ps
module tb_adc_sample_averager;

    localparam int CW = 10;
    localparam int ML = 4;
    localparam int TW = 16;
    localparam int FULL = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          meas_start = 1'b0;
    logic [2:0]    avg_log2 = '0;
    logic [TW-1:0] tmo_limit = '0;
    logic [CW-1:0] adc = '0;
    logic          adc_rdy = 1'b0;
    logic [CW-1:0] avg_data;
    logic          meas_done;
    logic          meas_busy;
    logic          timeout;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_avg = 0;

    typedef struct {
        int log2;
        int base;
        int stp;
        int exp_avg;
    } vec_t;

    vec_t vecs[8];

    always #5 clk = ~clk;

    adc_sample_averager #(.CADC_WIDTH(CW), .MAX_LOG2(ML), .TMO_WIDTH(TW)) dut (
        .CLK        (clk),
        .RST_N      (rst_n),
        .MEAS_START (meas_start),
        .AVG_LOG2   (avg_log2),
        .TMO_LIMIT  (tmo_limit),
        .ADC        (adc),
        .ADC_RDY    (adc_rdy),
        .AVG_DATA   (avg_data),
        .MEAS_DONE  (meas_done),
        .MEAS_BUSY  (meas_busy),
        .TIMEOUT    (timeout)
    );

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Rounded mean from plain integer arithmetic on the whole sample set.
    function automatic int ref_avg(input int sum, input int log2_req);
        int n;
        int cnt;
        int r;
        n   = (log2_req > ML) ? ML : log2_req;
        cnt = 1 << n;
        r   = (sum + cnt / 2) / cnt;
        return (r > FULL) ? FULL : r;
    endfunction

    function automatic int samples_for(input int log2_req);
        return 1 << ((log2_req > ML) ? ML : log2_req);
    endfunction

    task automatic launch(input int l2, input int lim);
        avg_log2   = 3'(l2);
        tmo_limit  = TW'(lim);
        meas_start = 1'b1;
        step();
    endtask

    task automatic pulse(input int v, input int w, input int g);
        adc     = CW'(v);
        adc_rdy = 1'b1;
        repeat (w) step();
        adc_rdy = 1'b0;
        repeat (g + 1) step();
    endtask

    task automatic wait_done(input string tag, input int budget, output int cyc);
        cyc = 0;
        while (!meas_done && cyc < budget) begin
            step();
            cyc++;
        end
        check({tag, "_done_seen"}, int'(meas_done), 1);
    endtask

    task automatic release_done(input string tag);
        meas_start = 1'b0;
        step();
        check({tag, "_done_hold"}, int'(meas_done), 1);
        step();
        check({tag, "_done_fall"}, int'(meas_done), 0);
        check({tag, "_idle"}, int'(meas_busy), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, cnt, l2, lim, k, sum, v;
        bit do_to;

        vecs[0] = '{2, 100, 1, 102};
        vecs[1] = '{4, 1023, 0, 1023};
        vecs[2] = '{0, 37, 0, 37};
        vecs[3] = '{1, 10, 1, 11};
        vecs[4] = '{3, 0, 3, 11};
        vecs[5] = '{7, 5, 2, 20};
        vecs[6] = '{2, 1, 0, 1};
        vecs[7] = '{1, 0, 1, 1};

        // Reset values
        repeat (3) step();
        check("rst_avg", int'(avg_data), 0);
        check("rst_done", int'(meas_done), 0);
        check("rst_busy", int'(meas_busy), 0);
        check("rst_tmo", int'(timeout), 0);
        rst_n = 1'b1;
        step();

        // Minimum latency: n=0, ready rises one cycle after the launch edge
        launch(0, 0);
        adc = CW'(200);
        adc_rdy = 1'b1;
        step();
        check("lat_busy", int'(meas_busy), 1);
        check("lat_done_c1", int'(meas_done), 0);
        adc_rdy = 1'b0;
        step();
        check("lat_done_c2", int'(meas_done), 0);
        step();
        check("lat_done_c3", int'(meas_done), 1);
        check("lat_avg", int'(avg_data), 200);
        exp_avg = 200;
        release_done("lat");

        // Timeout with no ready activity; previous result retained
        launch(2, 50);
        wait_done("tmo", 200, cyc);
        check("tmo_cycles", cyc, 51);
        check("tmo_flag", int'(timeout), 1);
        check("tmo_avg_kept", int'(avg_data), exp_avg);
        release_done("tmo");

        // Ready already high at launch is not a sample
        adc = CW'(999);
        adc_rdy = 1'b1;
        step();
        launch(0, 0);
        check("tmo_cleared", int'(timeout), 0);
        repeat (3) step();
        check("rdyhi_no_done", int'(meas_done), 0);
        check("rdyhi_busy", int'(meas_busy), 1);
        adc_rdy = 1'b0;
        step();
        pulse(37, 1, 0);
        wait_done("rdyhi", 10, cyc);
        check("rdyhi_avg", int'(avg_data), 37);
        exp_avg = 37;
        release_done("rdyhi");

        // Launch and ready edge in the same cycle: only the launch counts
        avg_log2 = 3'd0;
        tmo_limit = '0;
        adc = CW'(500);
        meas_start = 1'b1;
        adc_rdy = 1'b1;
        step();
        repeat (3) step();
        check("same_no_done", int'(meas_done), 0);
        check("same_busy", int'(meas_busy), 1);
        adc_rdy = 1'b0;
        step();
        pulse(61, 1, 0);
        wait_done("same", 10, cyc);
        check("same_avg", int'(avg_data), 61);
        exp_avg = 61;
        release_done("same");

        // Vector table
        for (int i = 0; i < 8; i++) begin
            cnt = samples_for(vecs[i].log2);
            launch(vecs[i].log2, 0);
            for (int s = 0; s < cnt; s++) begin
                if (s == cnt - 1) begin
                    check($sformatf("tbl%0d_busy_pre", i), int'(meas_busy), 1);
                    check($sformatf("tbl%0d_done_pre", i), int'(meas_done), 0);
                end
                pulse(vecs[i].base + s * vecs[i].stp, 1, 0);
            end
            wait_done($sformatf("tbl%0d", i), 10, cyc);
            check($sformatf("tbl%0d_avg", i), int'(avg_data), vecs[i].exp_avg);
            check($sformatf("tbl%0d_tmo", i), int'(timeout), 0);
            exp_avg = vecs[i].exp_avg;
            release_done($sformatf("tbl%0d", i));
        end

        // Clamped count (7 -> 16 samples), aborted after 5 samples
        launch(7, 0);
        for (int s = 0; s < 5; s++) pulse(900, 1, 1);
        check("abort_busy", int'(meas_busy), 1);
        meas_start = 1'b0;
        step();
        check("abort_idle", int'(meas_busy), 0);
        repeat (4) step();
        check("abort_done", int'(meas_done), 0);
        check("abort_avg", int'(avg_data), exp_avg);

        // Randomized measurements against the reference model
        for (int it = 0; it < 40; it++) begin
            l2 = $urandom_range(0, 7);
            cnt = samples_for(l2);
            do_to = ($urandom_range(0, 4) == 0);
            if (do_to) begin
                lim = $urandom_range(10, 30);
                k = $urandom_range(0, cnt - 1);
            end else begin
                lim = ($urandom_range(0, 1) == 1) ? 0 : 100;
                k = cnt;
            end
            launch(l2, lim);
            sum = 0;
            for (int s = 0; s < k; s++) begin
                v = $urandom_range(0, FULL);
                sum += v;
                pulse(v, $urandom_range(1, 3), $urandom_range(0, 5));
            end
            wait_done($sformatf("rnd%0d", it), lim + 40, cyc);
            if (do_to) begin
                check($sformatf("rnd%0d_tmo", it), int'(timeout), 1);
                check($sformatf("rnd%0d_avg_kept", it), int'(avg_data), exp_avg);
            end else begin
                exp_avg = ref_avg(sum, l2);
                check($sformatf("rnd%0d_avg", it), int'(avg_data), exp_avg);
                check($sformatf("rnd%0d_tmo", it), int'(timeout), 0);
            end
            release_done($sformatf("rnd%0d", it));
        end

        // Asynchronous reset in the middle of accumulation
        launch(2, 0);
        pulse(300, 1, 0);
        pulse(300, 1, 0);
        check("rstmid_busy_pre", int'(meas_busy), 1);
        #2;
        rst_n = 1'b0;
        meas_start = 1'b0;
        adc_rdy = 1'b0;
        #1;
        check("rstmid_avg", int'(avg_data), 0);
        check("rstmid_done", int'(meas_done), 0);
        check("rstmid_busy", int'(meas_busy), 0);
        check("rstmid_tmo", int'(timeout), 0);
        step();
        step();
        rst_n = 1'b1;
        step();
        step();
        check("rstmid_idle", int'(meas_busy), 0);
        check("rstmid_no_done", int'(meas_done), 0);
        launch(0, 0);
        pulse(37, 1, 0);
        wait_done("post_rst", 10, cyc);
        check("post_rst_avg", int'(avg_data), 37);
        release_done("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
